ram_port_arbiter: RTL
=====================

// Module: ram_port_arbiter
// PURPOSE
// - Shares the single RAM port between NREQ cache-side requesters (I$/D$ of each core).
// - Each requester sees a simple blocking protocol: hold ren/wen until wait drops.
// - Round-robin FSM arbiter; sits between the cache layer and the RAM model/bus.
// PARAMETERS
// - NREQ   4   number of requesters (>=2); index 0 = core0 I$, 1 = core0 D$, 2/3 = core1
// - AW     32  address width
// - DW     32  data width
// PORTS
// - CLK        in   1        clock, rising edge
// - nRST       in   1        reset, asynchronous, active-low
// - req_ren    in   NREQ     per-requester read request
// - req_wen    in   NREQ     per-requester write request
// - req_addr   in   NREQxAW  per-requester address (unpacked array)
// - req_store  in   NREQxDW  per-requester write data
// - req_wait   out  NREQ     1 = not done; 0 for exactly the completing cycle
// - req_load   out  DW       read data, valid while req_wait[grant_id] == 0
// - ram_ren    out  1        RAM read strobe
// - ram_wen    out  1        RAM write strobe
// - ram_addr   out  AW       RAM address
// - ram_store  out  DW       RAM write data
// - ram_load   in   DW       RAM read data
// - ram_ready  in   1        RAM completes the current access this cycle
// - grant_id   out  clog2(NREQ)  registered index of the current or last owner
// - busy       out  1        FSM is in ACCESS
// BEHAVIOUR
// - Reset values:
//   - state IDLE, rr_ptr = NREQ-1, grant_id = 0.
//   - req_wait all 1; ram_ren/ram_wen 0; ram_addr/ram_store 0; req_load 0; busy 0.
// - IDLE:
//   - If any (ren|wen), pick the first active index scanning rr_ptr+1 upward, modulo NREQ.
//   - Register the winner into grant_id; next state ACCESS.
//   - No RAM strobes are driven in IDLE.
// - ACCESS, RAM outputs (combinational from the granted requester's live inputs):
//   - wen=1 -> ram_wen=1, ram_ren=0.
//   - ren only -> ram_ren=1.
//   - ren and wen both set -> treated as a write.
// - ACCESS, completion:
//   - ram_ready=1 -> req_wait[g]=0 and req_load=ram_load that cycle.
//   - Then rr_ptr<=g, next state IDLE.
// - ACCESS, abort:
//   - Granted requester drops both ren and wen -> strobes drop the same cycle.
//   - No wait pulse; rr_ptr<=g; next state IDLE.
// - Non-granted requesters always see req_wait=1.
// - Latency: minimum 2 cycles request->completion (1 arbitration + 1 RAM cycle with ram_ready).
// - Back-to-back accesses always have one IDLE bubble between them.
// - Fairness: an active requester waits at most NREQ-1 other transactions (macro off).
// - ram_ready in IDLE is ignored.
// - Reset mid-ACCESS: strobes drop asynchronously, transaction lost; requester 0 wins first after release.
// - rr_ptr wraps NREQ-1 -> 0.
// CONFIGURATION
// - WRITE_PRIORITY_EN defined:
//   - In IDLE, if any req_wen is set, round-robin is restricted to writers only.
//   - Reads may starve under continuous writes; this is accepted.
// - WRITE_PRIORITY_EN undefined: pure round-robin over ren|wen regardless of type.
// TESTING
// - Single read: req_ren[0]=1, addr 0x40; ram_ready after 3 ACCESS cycles, ram_load=0xDEADBEEF.
//   - ram_ren=1 with ram_addr=0x40 from cycle 2.
//   - req_wait[0]=0 for exactly one cycle with req_load=0xDEADBEEF.
// - Round-robin from reset: all 4 req_ren held, ram_ready always 1 -> completions in order 0,1,2,3,0.
//   - One IDLE cycle between each completion.
// - Priority: rr_ptr=0, req_ren[1] and req_wen[3] (store 0x1234) held.
//   - Macro off: order 1 then 3.
//   - Macro on: 3 then 1; ram_store=0x1234 during 3's access.
// - Abort: req2 granted, ram_ready=0, req_ren[2] dropped.
//   - ram_ren=0 that cycle; next cycle IDLE.
//   - req_wait[2] never pulses low; the next winner is index 3.
// - Reset in ACCESS: nRST low mid-write.
//   - ram_wen=0 and req_wait all 1 immediately.
//   - After release with all requesting, index 0 is served first.
// - Both strobes: req_ren[1]=req_wen[1]=1 -> ram_wen=1, ram_ren=0, write completes normally.

Source files
------------

// File: rtl/ram_port_arbiter_if.sv
// Bundle of signals between the cache-side requesters, the shared RAM port and
// the arbiter that joins them. master = the arbiter, slave = requesters + RAM.
interface ram_port_arbiter_if #(
  parameter int NREQ = 4,
  parameter int AW   = 32,
  parameter int DW   = 32
);
  localparam int GW = $clog2(NREQ);

  logic [NREQ-1:0] req_ren;
  logic [NREQ-1:0] req_wen;
  logic [AW-1:0]   req_addr  [NREQ];
  logic [DW-1:0]   req_store [NREQ];
  logic [NREQ-1:0] req_wait;
  logic [DW-1:0]   req_load;

  logic            ram_ren;
  logic            ram_wen;
  logic [AW-1:0]   ram_addr;
  logic [DW-1:0]   ram_store;
  logic [DW-1:0]   ram_load;
  logic            ram_ready;

  logic [GW-1:0]   grant_id;
  logic            busy;

  modport master (
    input  req_ren, req_wen, req_addr, req_store, ram_load, ram_ready,
    output req_wait, req_load, ram_ren, ram_wen, ram_addr, ram_store,
           grant_id, busy
  );

  modport slave (
    output req_ren, req_wen, req_addr, req_store, ram_load, ram_ready,
    input  req_wait, req_load, ram_ren, ram_wen, ram_addr, ram_store,
           grant_id, busy
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one RAM port between NREQ blocking requesters.
// Define WRITE_PRIORITY_EN to restrict arbitration to writers whenever any are pending.
module ram_port_arbiter #(
  parameter int NREQ = 4,
  parameter int AW   = 32,
  parameter int DW   = 32
) (
  input  logic                CLK,
  input  logic                nRST,
  ram_port_arbiter_if.master  bus
);
  localparam int GW = $clog2(NREQ);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t          state;
  logic [GW-1:0]   rr_ptr;
  logic [GW-1:0]   grant_q;
  logic            busy_q;

  logic [NREQ-1:0] req_any;
  logic [NREQ-1:0] cand;
  logic            g_active;
  logic            serving;
  logic            done;

  // First set bit of mask strictly after ptr, wrapping modulo NREQ.
  function automatic logic [GW-1:0] rr_pick(input logic [NREQ-1:0] mask,
                                            input logic [GW-1:0]   ptr);
    logic [GW-1:0] win;
    int            idx;
    win = '0;
    for (int off = NREQ; off >= 1; off--) begin
      idx = (int'(ptr) + off) % NREQ;
      if (mask[idx]) win = GW'(idx);
    end
    return win;
  endfunction

  // NOTE: every output of this block gets a default before any condition,
  // so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    req_any = bus.req_ren | bus.req_wen;
`ifdef WRITE_PRIORITY_EN
    cand = (|bus.req_wen) ? bus.req_wen : req_any;
`else
    cand = req_any;
`endif

    g_active = bus.req_ren[grant_q] | bus.req_wen[grant_q];
    serving  = (state == ACCESS) && g_active;
    done     = serving && bus.ram_ready;

    // A set wen wins over ren, so a dual request is performed as a write.
    bus.ram_wen   = serving && bus.req_wen[grant_q];
    bus.ram_ren   = serving && !bus.req_wen[grant_q];
    bus.ram_addr  = serving ? bus.req_addr[grant_q]  : '0;
    bus.ram_store = serving ? bus.req_store[grant_q] : '0;

    bus.req_wait = '1;
    if (done) bus.req_wait[grant_q] = 1'b0;
    bus.req_load = done ? bus.ram_load : '0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state   <= IDLE;
      rr_ptr  <= GW'(NREQ - 1);
      grant_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|cand) begin
            grant_q <= rr_pick(cand, rr_ptr);
            state   <= ACCESS;
            busy_q  <= 1'b1;
          end
        end
        ACCESS: begin
          // Completion and abort both hand the pointer to the current owner.
          if (!g_active || bus.ram_ready) begin
            rr_ptr <= grant_q;
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.grant_id = grant_q;
  assign bus.busy     = busy_q;
endmodule
